prng_lfsr_stream_gen: RTL and testbench
=======================================

# prng_lfsr_stream_gen

Parametrised successor to the fixed 512-bit LFSR generator. It is a configurable Galois LFSR that produces STEP bits per clock and packs them into an OUT_W-bit word. Completed words are delivered over a valid/ready handshake, either one-shot or continuously. It supplies random masks and noise words to the FHE encryption datapath.

## Interface
- OUT_W, 512: output word width; must be a multiple of STEP.
- LFSR_W, 16: LFSR state width.
- SEED_W, 9: seed width; must be ≤ LFSR_W.
- STEP, 8: LFSR iterations (bits produced) per clock.
- TAPS, 16'hB400: Galois feedback mask, LFSR_W bits wide.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- seed  input  SEED_W  seed value, sampled when load_seed=1.
- load_seed  input  1  load seed into LFSR and abort any word in progress.
- start  input  1  begin word generation; honoured only in IDLE.
- continuous  input  1  after each handshake, refill automatically; sampled at the handshake edge.
- out_ready  input  1  consumer accepts prng_out.
- out_valid  output  1  prng_out holds a complete word.
- prng_out  output  OUT_W  generated word.
- done  output  1  one-cycle pulse when a word completes.
- busy  output  1  high in FILL.
- word_count  output  16  words accepted since reset or since the last load_seed; wraps at 65535 → 0.

## Operation
- LFSR step (Galois, right shift):
  - b = state[0];
  - state ← (state >> 1) ^ (b ? TAPS : 0);
  - emitted bit = b.
- Per FILL cycle, STEP steps run combinationally in sequence, producing b0..b(STEP-1).
- The chunk is packed with b0 at the chunk MSB.
- Buffer update: buf ← {buf[OUT_W-STEP-1:0], chunk}, so the first-generated bit ends at prng_out[OUT_W-1].
- Seed load: state ← zero-extended seed. A seed of 0 loads LFSR_W'd1 instead, so the LFSR never locks up.
- States:
  - IDLE: start → FILL; fill counter cleared.
  - FILL: shift one chunk per cycle. After OUT_W/STEP chunks → HOLD, with out_valid=1 and a done pulse.
  - HOLD: prng_out and out_valid held stable; the LFSR does not advance. When out_valid & out_ready: word_count+1, then continuous ? FILL : IDLE.
- load_seed has the highest priority in every state:
  - LFSR reloaded; fill counter, buf, out_valid and word_count cleared; state → IDLE.
  - A start asserted in the same cycle is ignored.
  - A pending HOLD word is discarded, with no handshake and no count.
- start outside IDLE is ignored.
- The LFSR advances only in FILL, so one stream is continuous across consecutive words.

## Timing
- Reset values:
  - state IDLE; LFSR = LFSR_W'd1.
  - buf/prng_out = 0; out_valid = 0; done = 0; busy = 0; word_count = 0.
- Let N = OUT_W/STEP (64 by default).
- start sampled at edge k: state FILL after k; chunks shift at edges k+1 … k+N.
- Edge k+N: out_valid=1, done=1; done drops after edge k+N+1.
- Fill latency is N+1 cycles from start to out_valid.
- busy is high from after edge k through edge k+N.
- Handshake at edge h:
  - out_valid drops after h.
  - If continuous, FILL begins; chunks shift at h+1 … h+N; out_valid rises again after h+N.
  - Sustained throughput is one word per N+1 cycles.
- out_ready while out_valid=0 has no effect.
- Reset asserted mid-FILL returns immediately to the reset values; the partial word is lost.

## Test plan
- Reset, then seed=1, start, out_ready held low → out_valid rises exactly 65 cycles after start.
  - prng_out[511:504]=8'h80 and prng_out[503:496]=8'h16.
  - The remaining bits match a software Galois model.
- seed=0, start → output identical to the seed=1 case (lock-up guard).
- Continuous mode with out_ready=1 → 4 words, each exactly 65 cycles apart.
  - Each word matches the next 512 bits of the model stream.
  - word_count=4.
- Stall: hold out_ready=0 for 100 cycles in HOLD → prng_out stable; done high exactly one cycle; LFSR frozen, so the next word continues the stream.
- load_seed at FILL chunk 30, with start asserted the same cycle → state IDLE, out_valid=0, word_count=0.
  - A subsequent start yields the fresh-seed word.
- Parameter sweep OUT_W=64, STEP=4, LFSR_W=32, TAPS=32'h80200003, seed=9'h1AB → out_valid 17 cycles after start; word matches the model.

Source files
------------

// File: rtl/prng_lfsr_stream_gen.sv
// Configurable Galois LFSR word generator: STEP bits per clock are packed into an
// OUT_W-bit word and delivered over valid/ready, one-shot or continuously.
module prng_lfsr_stream_gen #(
  parameter int                OUT_W  = 512,
  parameter int                LFSR_W = 16,
  parameter int                SEED_W = 9,
  parameter int                STEP   = 8,
  parameter logic [LFSR_W-1:0] TAPS   = 16'hB400
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SEED_W-1:0] seed,
  input  logic              load_seed,
  input  logic              start,
  input  logic              continuous,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [OUT_W-1:0]  prng_out,
  output logic              done,
  output logic              busy,
  output logic [15:0]       word_count
);

  localparam int N     = OUT_W / STEP;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_next, seed_val;
  logic [STEP-1:0]     chunk;
  logic [OUT_W-1:0]    word_q;
  logic [CNT_W-1:0]    fill_cnt_q;
  logic                out_valid_q, done_q;
  logic [15:0]         word_count_q;
  logic                shift_en, fill_last, accept, clr_cnt;

  // A zero seed would lock the LFSR at zero forever, so it is mapped to 1.
  assign seed_val = (seed == '0) ? LFSR_W'(1) : LFSR_W'(seed);

  // STEP Galois iterations unrolled in one cycle; the first bit lands at the chunk MSB.
  always_comb begin : lfsr_unroll
    logic [LFSR_W-1:0] s;
    logic              b;
    s     = lfsr_q;
    chunk = '0;
    for (int i = 0; i < STEP; i++) begin
      b     = s[0];
      chunk = (chunk << 1) | STEP'(b);
      s     = (s >> 1) ^ (b ? TAPS : '0);
    end
    lfsr_next = s;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin : next_state
    state_d   = state_q;
    shift_en  = 1'b0;
    fill_last = 1'b0;
    accept    = 1'b0;
    clr_cnt   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FILL;
          clr_cnt = 1'b1;
        end
      end
      FILL: begin
        shift_en = 1'b1;
        if (fill_cnt_q == LAST_CHUNK) begin
          fill_last = 1'b1;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          accept  = 1'b1;
          state_d = continuous ? FILL : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // load_seed overrides everything, including a start in the same cycle.
    if (load_seed) begin
      state_d   = IDLE;
      shift_en  = 1'b0;
      fill_last = 1'b0;
      accept    = 1'b0;
      clr_cnt   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // NOTE: the word register is ordinary flops (not a RAM), so it is reset to a known zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q       <= LFSR_W'(1);
      word_q       <= '0;
      fill_cnt_q   <= '0;
      out_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      word_count_q <= '0;
    end else if (load_seed) begin
      lfsr_q       <= seed_val;
      word_q       <= '0;
      fill_cnt_q   <= '0;
      out_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      word_count_q <= '0;
    end else begin
      done_q <= fill_last;
      if (clr_cnt) fill_cnt_q <= '0;
      if (shift_en) begin
        lfsr_q     <= lfsr_next;
        word_q     <= (word_q << STEP) | OUT_W'(chunk);
        fill_cnt_q <= fill_last ? '0 : fill_cnt_q + CNT_W'(1);
      end
      if (fill_last) out_valid_q <= 1'b1;
      if (accept) begin
        out_valid_q  <= 1'b0;
        word_count_q <= word_count_q + 16'd1;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign prng_out   = word_q;
  assign done       = done_q;
  assign busy       = (state_q == FILL);
  assign word_count = word_count_q;

endmodule

// File: tb/tb_prng_lfsr_stream_gen.sv
// Directed bench for prng_lfsr_stream_gen: default build plus a 64-bit/4-step/32-bit LFSR build.
module tb_prng_lfsr_stream_gen;

  logic         clk = 1'b0;
  logic         rst;
  logic [8:0]   seed;
  logic         load_seed, start, continuous, out_ready;
  logic         out_valid, done, busy;
  logic [511:0] prng_out;
  logic [15:0]  word_count;

  logic [8:0]   s_seed;
  logic         s_load, s_start, s_cont, s_ready;
  logic         s_valid, s_done, s_busy;
  logic [63:0]  s_out;
  logic [15:0]  s_wc;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  prng_lfsr_stream_gen dut (
    .clk(clk), .rst(rst), .seed(seed), .load_seed(load_seed), .start(start),
    .continuous(continuous), .out_ready(out_ready), .out_valid(out_valid),
    .prng_out(prng_out), .done(done), .busy(busy), .word_count(word_count)
  );

  prng_lfsr_stream_gen #(
    .OUT_W(64), .LFSR_W(32), .SEED_W(9), .STEP(4), .TAPS(32'h80200003)
  ) dut_small (
    .clk(clk), .rst(rst), .seed(s_seed), .load_seed(s_load), .start(s_start),
    .continuous(s_cont), .out_ready(s_ready), .out_valid(s_valid),
    .prng_out(s_out), .done(s_done), .busy(s_busy), .word_count(s_wc)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Bit-serial Galois reference: first generated bit ends up at w[out_w-1].
  task automatic model_gen(input int out_w, input logic [31:0] taps,
                           inout logic [31:0] st, output logic [511:0] w);
    logic b;
    w = '0;
    for (int i = 0; i < out_w; i++) begin
      b  = st[0];
      w  = {w[510:0], b};
      st = (st >> 1) ^ (b ? taps : 32'h0);
    end
  endtask

  // Pulse start, then count negedges until out_valid (1 = first sample after the start edge).
  task automatic fill_big(output int lat, output logic busy1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy1 = busy;
    lat   = 1;
    while (!out_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0]  ms;
    logic [511:0] exp_w, held;
    logic         b1;
    int           lat, n, got, prev, done_hits, changed;

    rst = 1'b0; seed = '0; load_seed = 0; start = 0; continuous = 0; out_ready = 0;
    s_seed = '0; s_load = 0; s_start = 0; s_cont = 0; s_ready = 0;
    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_out", prng_out, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_wc", word_count, 0);
    rst = 1'b1;
    @(negedge clk);

    // Seed 1, one-shot word, consumer stalled.
    seed = 9'h001; load_seed = 1'b1;
    @(negedge clk);
    load_seed = 1'b0;
    fill_big(lat, b1);
    check("t1_busy_start", b1, 1);
    check("t1_latency", lat, 65);
    check("t1_done", done, 1);
    check("t1_busy_end", busy, 0);
    check("t1_byte0", prng_out[511:504], 8'h80);
    check("t1_byte1", prng_out[503:496], 8'h16);
    ms = 32'h1;
    model_gen(512, 32'h0000B400, ms, exp_w);
    check("t1_word", prng_out, exp_w);

    held = prng_out; done_hits = 0; changed = 0;
    repeat (100) begin
      @(negedge clk);
      if (done) done_hits++;
      if (prng_out !== held || !out_valid) changed++;
    end
    check("stall_stable", changed, 0);
    check("stall_done_once", done_hits, 0);

    handshake();
    check("hs_valid_drop", out_valid, 0);
    check("hs_wc", word_count, 1);
    check("hs_idle", busy, 0);

    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    out_ready = 1'b0;
    check("ready_no_valid_wc", word_count, 1);

    // LFSR was frozen in HOLD/IDLE: next word continues the same stream.
    fill_big(lat, b1);
    check("t2_latency", lat, 65);
    model_gen(512, 32'h0000B400, ms, exp_w);
    check("t2_stream_continues", prng_out, exp_w);
    handshake();
    check("t2_wc", word_count, 2);

    // Seed 0 behaves like seed 1.
    seed = 9'h000; load_seed = 1'b1;
    @(negedge clk);
    load_seed = 1'b0;
    check("ld_wc_clear", word_count, 0);
    fill_big(lat, b1);
    ms = 32'h1;
    model_gen(512, 32'h0000B400, ms, exp_w);
    check("seed0_word", prng_out, exp_w);
    handshake();

    // Continuous mode, four back-to-back words.
    seed = 9'h1AB; load_seed = 1'b1;
    @(negedge clk);
    load_seed = 1'b0;
    ms = 32'h1AB;
    continuous = 1'b1; out_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; n = 1; got = 0; prev = 0;
    while (got < 4 && n < 400) begin
      if (out_valid) begin
        model_gen(512, 32'h0000B400, ms, exp_w);
        check($sformatf("cont_word%0d", got), prng_out, exp_w);
        check($sformatf("cont_gap%0d", got), n - prev, 65);
        prev = n;
        got++;
        if (got == 4) continuous = 1'b0;
      end
      if (got < 4) begin
        @(negedge clk);
        n++;
      end
    end
    check("cont_got4", got, 4);
    @(negedge clk);
    out_ready = 1'b0;
    check("cont_wc", word_count, 4);
    check("cont_idle", busy, 0);
    check("cont_valid_low", out_valid, 0);

    // load_seed at chunk 30 together with start.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    seed = 9'h055; load_seed = 1'b1; start = 1'b1;
    @(negedge clk);
    load_seed = 1'b0; start = 1'b0;
    check("abort_idle", busy, 0);
    check("abort_valid", out_valid, 0);
    check("abort_wc", word_count, 0);
    check("abort_word", prng_out, 0);
    repeat (3) @(negedge clk);
    check("abort_start_ignored", busy, 0);
    fill_big(lat, b1);
    check("fresh_latency", lat, 65);
    ms = 32'h055;
    model_gen(512, 32'h0000B400, ms, exp_w);
    check("fresh_word", prng_out, exp_w);
    handshake();
    check("fresh_wc", word_count, 1);

    // Asynchronous reset in the middle of a fill.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_word", prng_out, 0);
    check("midrst_wc", word_count, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    fill_big(lat, b1);
    ms = 32'h1;
    model_gen(512, 32'h0000B400, ms, exp_w);
    check("midrst_reset_lfsr_word", prng_out, exp_w);

    // Small configuration.
    s_seed = 9'h1AB; s_load = 1'b1;
    @(negedge clk);
    s_load = 1'b0; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0; n = 1;
    while (!s_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("small_latency", n, 17);
    check("small_done", s_done, 1);
    ms = 32'h1AB;
    model_gen(64, 32'h80200003, ms, exp_w);
    check("small_word", {448'b0, s_out}, exp_w);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
